// File: rtl/beam_scan_if.sv
// rtl/beam_scan_if.sv - beam_scan control, memory and result bus; BEAM_PWR_STREAM_EN adds the per-beam power stream
interface beam_scan_if #(
   parameter int NCH    = 4,
   parameter int NBEAMS = 13,
   parameter int BINW   = 10,
   parameter int DW     = 14,
   parameter int CW     = 14,
   parameter int ACCW   = 32
);
   localparam int BW  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
   localparam int CAW = $clog2(NBEAMS * NCH);

   logic                  start;
   logic [BINW-1:0]       bin;
   logic [BINW-1:0]       spec_addr;
   logic [NCH*2*DW-1:0]   spec_q;
   logic [CAW-1:0]        coef_addr;
   logic [2*CW-1:0]       coef_q;
   logic                  busy;
   logic                  done;
   logic [BW-1:0]         best_beam;
   logic [2*ACCW:0]       best_pwr;
   logic signed [7:0]     doa;
`ifdef BEAM_PWR_STREAM_EN
   logic                  pwr_valid;
   logic [BW-1:0]         pwr_beam;
   logic [2*ACCW:0]       pwr_data;
`endif

   modport slave (
      input  start, bin, spec_q, coef_q,
      output spec_addr, coef_addr, busy, done, best_beam, best_pwr, doa
`ifdef BEAM_PWR_STREAM_EN
      , output pwr_valid, pwr_beam, pwr_data
`endif
   );

   modport master (
      output start, bin, spec_q, coef_q,
      input  spec_addr, coef_addr, busy, done, best_beam, best_pwr, doa
`ifdef BEAM_PWR_STREAM_EN
      , input pwr_valid, pwr_beam, pwr_data
`endif
   );
endinterface

// File: rtl/beam_scan.sv
// rtl/beam_scan.sv - delay-and-sum beam scanner reporting the max-power beam and its DOA
// Optional per-beam power stream enabled by defining BEAM_PWR_STREAM_EN.
module beam_scan #(
   parameter int NCH     = 4,
   parameter int NBEAMS  = 13,
   parameter int BINW    = 10,
   parameter int DW      = 14,
   parameter int CW      = 14,
   parameter int ACCW    = 32,
   parameter int RAM_LAT = 2,
   parameter int ROM_LAT = 2,
   parameter int ANG0    = -90,
   parameter int ASTEP   = 15
) (
   input  logic      clk,
   input  logic      reset,
   beam_scan_if.slave bus
);
   localparam int BW     = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
   localparam int CAW    = $clog2(NBEAMS * NCH);
   localparam int CHW    = $clog2(NCH);
   localparam int PW     = 2 * ACCW + 1;
   localparam int LATMAX = (RAM_LAT > ROM_LAT) ? RAM_LAT : ROM_LAT;
   localparam int CNTW   = $clog2(LATMAX + 1);

   typedef enum logic [2:0] {IDLE, FETCH, COEF, MAC, CMP, DONE} state_t;

   state_t                  state, state_nx;
   logic [CNTW-1:0]         cnt;
   logic [CHW-1:0]          ch;
   logic [BW-1:0]           beam;
   logic signed [ACCW-1:0]  acc_re, acc_im;
   logic signed [DW-1:0]    spec_re [NCH];
   logic signed [DW-1:0]    spec_im [NCH];
   logic [PW-1:0]           max_pwr;
   logic [BW-1:0]           max_beam;
   logic [BINW-1:0]         spec_addr;
   logic [CAW-1:0]          coef_addr;
   logic [BW-1:0]           best_beam;
   logic [PW-1:0]           best_pwr;
   logic signed [7:0]       doa;

   logic                    last_ram, last_rom, last_ch, last_beam;
   logic signed [ACCW-1:0]  cr, ci, sr, si, prod_re, prod_im;
   logic signed [PW-1:0]    are, aim;
   logic [PW-1:0]           pwr, new_max_pwr;
   logic [BW-1:0]           new_max_beam;
   logic signed [7:0]       doa_nx;

   assign last_ram  = (cnt == CNTW'(RAM_LAT - 1));
   assign last_rom  = (cnt == CNTW'(ROM_LAT - 1));
   assign last_ch   = (ch == CHW'(NCH - 1));
   assign last_beam = (beam == BW'(NBEAMS - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = FETCH;
         FETCH:   if (last_ram) state_nx = COEF;
         COEF:    if (last_rom) state_nx = MAC;
         MAC:     state_nx = last_ch ? CMP : COEF;
         CMP:     state_nx = last_beam ? DONE : COEF;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operands are sign-extended to ACCW first, so ACCW-wide products are exact.
   always_comb begin
      cr = {{(ACCW-CW){bus.coef_q[2*CW-1]}}, bus.coef_q[2*CW-1:CW]};
      ci = {{(ACCW-CW){bus.coef_q[CW-1]}}, bus.coef_q[CW-1:0]};
      sr = {{(ACCW-DW){spec_re[ch][DW-1]}}, spec_re[ch]};
      si = {{(ACCW-DW){spec_im[ch][DW-1]}}, spec_im[ch]};
      prod_re = cr * sr - ci * si;
      prod_im = cr * si + ci * sr;
      are = {{(ACCW+1){acc_re[ACCW-1]}}, acc_re};
      aim = {{(ACCW+1){acc_im[ACCW-1]}}, acc_im};
      pwr = are * are + aim * aim;
      new_max_pwr  = max_pwr;
      new_max_beam = max_beam;
      if (pwr > max_pwr) begin
         new_max_pwr  = pwr;
         new_max_beam = beam;
      end
      doa_nx = 8'(ANG0 + ASTEP * int'(new_max_beam));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         ch        <= '0;
         beam      <= '0;
         acc_re    <= '0;
         acc_im    <= '0;
         max_pwr   <= '0;
         max_beam  <= '0;
         spec_addr <= '0;
         coef_addr <= '0;
         best_beam <= '0;
         best_pwr  <= '0;
         doa       <= '0;
         for (int k = 0; k < NCH; k++) begin
            spec_re[k] <= '0;
            spec_im[k] <= '0;
         end
`ifdef BEAM_PWR_STREAM_EN
         bus.pwr_valid <= 1'b0;
         bus.pwr_beam  <= '0;
         bus.pwr_data  <= '0;
`endif
      end else begin
`ifdef BEAM_PWR_STREAM_EN
         bus.pwr_valid <= (state == CMP);
         bus.pwr_beam  <= beam;
         bus.pwr_data  <= pwr;
`endif
         case (state)
            IDLE: begin
               if (bus.start) begin
                  spec_addr <= bus.bin;
                  max_pwr   <= '0;
                  max_beam  <= '0;
                  cnt       <= '0;
               end
            end
            FETCH: begin
               cnt <= cnt + 1'b1;
               if (last_ram) begin
                  for (int k = 0; k < NCH; k++) begin
                     spec_re[k] <= bus.spec_q[k*2*DW+DW +: DW];
                     spec_im[k] <= bus.spec_q[k*2*DW +: DW];
                  end
                  cnt       <= '0;
                  beam      <= '0;
                  ch        <= '0;
                  coef_addr <= '0;
               end
            end
            COEF: begin
               cnt <= last_rom ? '0 : cnt + 1'b1;
            end
            MAC: begin
               acc_re <= acc_re + prod_re;
               acc_im <= acc_im + prod_im;
               if (!last_ch) begin
                  ch        <= ch + 1'b1;
                  coef_addr <= coef_addr + 1'b1;
               end
            end
            CMP: begin
               // Results publish here so they land together with the done pulse.
               max_pwr  <= new_max_pwr;
               max_beam <= new_max_beam;
               acc_re   <= '0;
               acc_im   <= '0;
               ch       <= '0;
               if (!last_beam) begin
                  beam      <= beam + 1'b1;
                  coef_addr <= coef_addr + 1'b1;
               end else begin
                  best_beam <= new_max_beam;
                  best_pwr  <= new_max_pwr;
                  doa       <= doa_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.spec_addr = spec_addr;
   assign bus.coef_addr = coef_addr;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.best_beam = best_beam;
   assign bus.best_pwr  = best_pwr;
   assign bus.doa       = doa;
endmodule
